// File: rtl/instr_mem_loader.sv
// Byte-serial program loader into a 35-bit instruction store, plus a 1-cycle-latency fetch port.
// A byte is taken when load_valid && load_ready; a fetch when fetch_req && fetch_ready (RUN only).
module instr_mem_loader #(
    parameter int DEPTH = 64,
    parameter int PTR_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic [7:0]       load_byte,
    input  logic             load_end,
    output logic             load_ready,
    output logic             load_done,
    output logic             load_err,
    output logic [PTR_W-1:0] prog_len,
    input  logic             fetch_req,
    input  logic [31:0]      fetch_addr,
    output logic             fetch_ready,
    output logic             fetch_valid,
    output logic [34:0]      fetch_instr,
    output logic             fetch_err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [2:0]        bcnt_q, bcnt_d;
    logic [31:0]       shreg_q, shreg_d;
    logic              load_err_q, load_err_d;
    logic              load_done_q, load_done_d;
    logic              fetch_valid_q;
    logic              fetch_err_q;
    logic [34:0]       fetch_instr_q;
    logic [34:0]       mem [DEPTH];

    logic              byte_acc;
    logic              end_evt;
    logic              word_bad;
    logic              wr_en;
    logic              full_evt;
    logic              fetch_acc;
    logic              fetch_hit;
    logic [39:0]       word_img;
    logic [2:0]        bcnt_after;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (load_start)                state_d = S_LOAD;
                else if (end_evt || full_evt)  state_d = S_RUN;
            end
            S_RUN: begin
                if (load_start) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        load_ready  = 1'b0;
        fetch_ready = 1'b0;
        case (state_q)
            S_LOAD:  load_ready  = (wptr_q < DEPTH_P);
            S_RUN:   fetch_ready = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        byte_acc   = (state_q == S_LOAD) && load_valid && load_ready && !load_start;
        end_evt    = (state_q == S_LOAD) && load_end && !load_start;
        word_img   = {shreg_q, load_byte};
        word_bad   = |word_img[39:35];
        wr_en      = byte_acc && (bcnt_q == 3'd4) && !word_bad;
        full_evt   = wr_en && (wptr_q == LAST_P);
        // load_end is judged on the byte count after this cycle's byte
        if (byte_acc) bcnt_after = (bcnt_q == 3'd4) ? 3'd0 : bcnt_q + 3'd1;
        else          bcnt_after = bcnt_q;
        fetch_acc  = fetch_req && fetch_ready;
        fetch_hit  = fetch_addr < 32'(wptr_q);
    end

    always_comb begin
        wptr_d      = wptr_q;
        bcnt_d      = bcnt_after;
        shreg_d     = shreg_q;
        load_err_d  = load_err_q;
        load_done_d = 1'b0;
        if (load_start) begin
            wptr_d     = '0;
            bcnt_d     = '0;
            load_err_d = 1'b0;
        end else begin
            if (byte_acc) begin
                shreg_d = {shreg_q[23:0], load_byte};
                if ((bcnt_q == 3'd4) && word_bad) load_err_d = 1'b1;
            end
            if (wr_en) wptr_d = wptr_q + PTR_W'(1);
            if (end_evt && (bcnt_after != 3'd0)) begin
                load_err_d = 1'b1;
                bcnt_d     = '0;
            end
            if (end_evt || full_evt) load_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q        <= '0;
            bcnt_q        <= '0;
            shreg_q       <= '0;
            load_err_q    <= 1'b0;
            load_done_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_instr_q <= '0;
        end else begin
            wptr_q        <= wptr_d;
            bcnt_q        <= bcnt_d;
            shreg_q       <= shreg_d;
            load_err_q    <= load_err_d;
            load_done_q   <= load_done_d;
            fetch_valid_q <= fetch_acc;
            fetch_err_q   <= fetch_acc && !fetch_hit;
            fetch_instr_q <= (fetch_acc && fetch_hit) ? mem[fetch_addr[AW-1:0]] : '0;
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wptr_q[AW-1:0]] <= word_img[34:0];
        end
    end

    assign load_done   = load_done_q;
    assign load_err    = load_err_q;
    assign prog_len    = wptr_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_err   = fetch_err_q;
    assign fetch_instr = fetch_instr_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader; fetch responses are checked against a scoreboard queue.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_end;
    logic        load_ready;
    logic        load_done;
    logic        load_err;
    logic [6:0]  prog_len;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [34:0] fetch_instr;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    logic [35:0] sb[$];
    logic [35:0] mon_e;
    logic [34:0] exp_mem [64];
    logic [7:0]  wb [5];

    localparam logic [35:0] ERR_RESP = {1'b1, 35'h0};

    instr_mem_loader #(.DEPTH(64), .PTR_W(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_end   (load_end),
        .load_ready (load_ready),
        .load_done  (load_done),
        .load_err   (load_err),
        .prog_len   (prog_len),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [35:0] expv);
        fetch_req  = 1'b1;
        fetch_addr = a;
        sb.push_back(expv);
        tick();
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Response monitor: every fetch_valid must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (fetch_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_fetch_valid", 64'(fetch_valid), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                check("fetch_instr", 64'(fetch_instr), 64'(mon_e[34:0]));
                check("fetch_err", 64'(fetch_err), 64'(mon_e[35]));
            end
        end else begin
            check("instr_zero_when_idle", 64'(fetch_instr), 64'(0));
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_byte = 8'h0;
        load_end = 1'b0; fetch_req = 1'b0; fetch_addr = 32'h0;
        repeat (3) tick();
        check("rst_load_ready", 64'(load_ready), 64'(0));
        check("rst_load_done", 64'(load_done), 64'(0));
        check("rst_load_err", 64'(load_err), 64'(0));
        check("rst_prog_len", 64'(prog_len), 64'(0));
        check("rst_fetch_ready", 64'(fetch_ready), 64'(0));
        check("rst_fetch_valid", 64'(fetch_valid), 64'(0));
        check("rst_fetch_instr", 64'(fetch_instr), 64'(0));
        check("rst_fetch_err", 64'(fetch_err), 64'(0));
        reset = 1'b0;

        // Fetch in IDLE gets no response; load_end outside LOAD is ignored
        fetch_req = 1'b1; load_end = 1'b1;
        tick();
        fetch_req = 1'b0; load_end = 1'b0;
        check("idle_fetch_ignored", 64'(fetch_valid), 64'(0));
        check("idle_end_ignored", 64'(load_done), 64'(0));

        // Normal two-word load
        pulse_start();
        check("load_ready_in_load", 64'(load_ready), 64'(1));
        check("start_prog_len", 64'(prog_len), 64'(0));
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h05); send_byte(8'hFF); send_byte(8'hFE);
        send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00); send_byte(8'h07);
        check("no_done_before_end", 64'(load_done), 64'(0));
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        check("norm_done", 64'(load_done), 64'(1));
        check("norm_prog_len", 64'(prog_len), 64'(2));
        check("norm_err", 64'(load_err), 64'(0));
        check("norm_run_fetch_ready", 64'(fetch_ready), 64'(1));
        check("norm_run_load_ready", 64'(load_ready), 64'(0));
        tick();
        check("norm_done_one_cycle", 64'(load_done), 64'(0));

        // Back-to-back fetches, including one far out of range
        fetch(32'd0, {1'b0, 35'h1_0005_FFFE});
        check("fetch_lat0", 64'(fetch_valid), 64'(1));
        fetch(32'd1, {1'b0, 35'h2_1234_0007});
        check("fetch_lat1", 64'(fetch_valid), 64'(1));
        fetch(32'd2, ERR_RESP);
        fetch(32'h1000_0000, ERR_RESP);
        fetch_req = 1'b0;
        tick();
        check("fetch_no_extra", 64'(fetch_valid), 64'(0));

        // Bad top byte, then a good word, then a partial word
        pulse_start();
        check("restart_prog_len", 64'(prog_len), 64'(0));
        send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("bad_err", 64'(load_err), 64'(1));
        check("bad_prog_len", 64'(prog_len), 64'(0));
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h2A);
        check("good_after_bad_len", 64'(prog_len), 64'(1));
        check("err_sticky", 64'(load_err), 64'(1));
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        check("partial_done", 64'(load_done), 64'(1));
        check("partial_prog_len", 64'(prog_len), 64'(1));
        check("partial_err", 64'(load_err), 64'(1));
        fetch(32'd0, {1'b0, 35'h2A});
        fetch(32'd1, ERR_RESP);
        fetch_req = 1'b0;

        // Final byte and load_end in the same cycle; the byte completes the word
        pulse_start();
        check("restart_clears_err", 64'(load_err), 64'(0));
        send_byte(8'h00); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        load_valid = 1'b1; load_byte = 8'h44; load_end = 1'b1;
        tick();
        load_valid = 1'b0; load_end = 1'b0;
        check("same_cycle_done", 64'(load_done), 64'(1));
        check("same_cycle_len", 64'(prog_len), 64'(1));
        check("same_cycle_err", 64'(load_err), 64'(0));

        // load_start coinciding with a fetch: response still uses the old image
        load_start = 1'b1;
        fetch(32'd0, {1'b0, 35'h0_1122_3344});
        load_start = 1'b0; fetch_req = 1'b0;
        check("start_fetch_ready_drop", 64'(fetch_ready), 64'(0));
        check("start_fetch_len_clear", 64'(prog_len), 64'(0));

        // Fill all 64 words without load_end
        for (int i = 0; i < 64; i++) begin
            wb[0] = 8'(i & 7);
            wb[1] = 8'(i);
            wb[2] = ~8'(i);
            wb[3] = 8'h5A;
            wb[4] = 8'(i * 3);
            exp_mem[i] = {wb[0][2:0], wb[1], wb[2], wb[3], wb[4]};
            for (int j = 0; j < 5; j++) send_byte(wb[j]);
            if (i == 62) begin
                check("full_minus1_len", 64'(prog_len), 64'(63));
                check("full_minus1_ready", 64'(load_ready), 64'(1));
                check("full_minus1_done", 64'(load_done), 64'(0));
            end
        end
        check("full_done", 64'(load_done), 64'(1));
        check("full_load_ready", 64'(load_ready), 64'(0));
        check("full_run", 64'(fetch_ready), 64'(1));
        check("full_prog_len", 64'(prog_len), 64'(64));
        check("full_err", 64'(load_err), 64'(0));

        // Bytes and load_end in RUN are ignored
        load_end = 1'b1;
        send_byte(8'h00);
        load_end = 1'b0;
        check("run_ignore_len", 64'(prog_len), 64'(64));
        check("run_ignore_done", 64'(load_done), 64'(0));

        fetch(32'd0, {1'b0, exp_mem[0]});
        fetch(32'd37, {1'b0, exp_mem[37]});
        fetch(32'd63, {1'b0, exp_mem[63]});
        fetch(32'd64, ERR_RESP);
        fetch_req = 1'b0;
        tick();

        // Reset on the edge a fetch would be accepted drops it
        fetch_req = 1'b1; fetch_addr = 32'd5; reset = 1'b1;
        tick();
        fetch_req = 1'b0; reset = 1'b0;
        check("rst_fetch_dropped", 64'(fetch_valid), 64'(0));
        check("rst_to_idle", 64'(fetch_ready), 64'(0));

        // Reset mid-load, with load_start asserted too (reset wins)
        pulse_start();
        for (int k = 0; k < 12; k++) send_byte(8'(k));
        check("midload_len", 64'(prog_len), 64'(2));
        reset = 1'b1; load_start = 1'b1;
        tick();
        reset = 1'b0; load_start = 1'b0;
        check("midrst_prog_len", 64'(prog_len), 64'(0));
        check("midrst_fetch_ready", 64'(fetch_ready), 64'(0));
        check("midrst_load_ready", 64'(load_ready), 64'(0));
        fetch_req = 1'b1; fetch_addr = 32'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("midrst_no_fetch_valid", 64'(fetch_valid), 64'(0));
        end
        fetch_req = 1'b0;

        repeat (2) tick();
        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
